bcd_down_timer: RTL
===================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 SHALL have parameter NDIG, default 2: number of cascaded BCD digits (1..4).
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load  input  1  synchronous load strobe for count and reload register.
REQ-005 SHALL have port load_val  input  4*NDIG  BCD value, digit 0 in bits [3:0].
REQ-006 SHALL have port start  input  1  single-cycle start or restart request.
REQ-007 SHALL have port stop  input  1  abort request, returns to IDLE holding Q.
REQ-008 SHALL have port en  input  1  count enable, one decrement per enabled cycle.
REQ-009 SHALL have port auto_reload  input  1  reload on terminal count instead of stopping.
REQ-010 SHALL have port Q  output  4*NDIG  registered BCD count.
REQ-011 SHALL have port state  output  2  FSM state encoding: IDLE=0, RUN=1, DONE=2.
REQ-012 SHALL have port tc  output  1  combinational, high when Q == 0.
REQ-013 SHALL have port done  output  1  registered one-cycle pulse on terminal count.

Function
REQ-014 SHALL be a three-state FSM: IDLE, RUN and DONE.
REQ-015 SHALL clamp any load_val digit greater than 9 to 9 on load, in both Q and reload_reg.
REQ-016 SHALL, on load in any state, set Q and reload_reg from load_val; load has priority over every other input; the state is unchanged unless it is DONE, in which case the state goes to IDLE.
REQ-017 SHALL, in IDLE, ignore en; start with Q != 0 goes to RUN next cycle; start with Q == 0 stays in IDLE with no done pulse.
REQ-018 SHALL, in RUN with en=1 and Q != 0, decrement Q by 1 in BCD (digit 0 -> 9 with borrow into the next digit), e.g. 20 -> 19 and 10 -> 09.
REQ-019 SHALL, in RUN with en=1 and Q == 0, assert done for exactly the next cycle.
REQ-020 SHALL, in the REQ-019 case with auto_reload=1, set Q to reload_reg and stay in RUN.
REQ-021 SHALL, in the REQ-019 case with auto_reload=0, go to DONE with Q held at 0.
REQ-022 SHALL, in RUN with en=0, hold Q.
REQ-023 SHALL, on stop in RUN, go to IDLE holding Q; if stop and start are both high, stop wins.
REQ-024 SHALL, in DONE, reload Q from reload_reg and go to RUN on start; otherwise hold.
REQ-025 SHALL decrement within a single cycle (zero latency) with no inter-digit ripple delay.
REQ-026 SHALL treat reload_reg = 0 with auto_reload=1 as a done pulse on every enabled cycle.

Reset
REQ-027 SHALL, on Reset, asynchronously force Q = 0, reload_reg = 0, state = IDLE and done = 0.
REQ-028 SHALL, when Reset is asserted mid-RUN, abort the count with no done pulse.
REQ-029 SHALL resume normal operation on the first rising CLK edge after Reset deasserts.

Structure
REQ-030 SHALL place the state encoding constants and the BCD digit width (4) in a shared package, bcd_timer_pkg.
REQ-031 SHALL use sub-module bcd_down_digit (4-bit value, borrow_in, borrow_out, decremented value) instantiated NDIG times in a generate loop.
REQ-032 SHALL keep the FSM, the reload register and the done register in the top module.

Verification (NDIG=2)
REQ-033 SHALL cover: Reset pulse mid-count -> Q=00, state=IDLE, done=0 immediately, without waiting for a clock edge.
REQ-034 SHALL cover: load 12, start, en=1 held -> Q sequence 12,11,10,09,...,00, then one done pulse, then state=DONE with Q=00.
REQ-035 SHALL cover: load 03, auto_reload=1, start, en=1 -> 03,02,01,00,03,02..., with a done pulse on each 00->03 transition.
REQ-036 SHALL cover: load 0xAF (invalid BCD) -> Q=99; then start with en toggling every other cycle -> Q decrements only on en=1 cycles.
REQ-037 SHALL cover: stop and start asserted together in RUN at Q=45 -> IDLE with Q=45; a later start -> RUN from 45.
REQ-038 SHALL cover: start in IDLE with Q=00 -> stays IDLE, no done pulse; load 07 in DONE -> IDLE with Q=07.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// ============================================================================
// Module : bcd_timer_pkg
// Brief  : Shared FSM state encodings, BCD digit width and digit clamp helper
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_timer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Non-BCD nibbles (A..F) saturate to 9 so the counter never holds an illegal digit.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_down_digit.sv
// ============================================================================
// Module : bcd_down_digit
// Brief  : One BCD digit of a down counter: combinational decrement with borrow
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_digit
    import bcd_timer_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_value,
    input  logic               i_borrow_in,
    output logic               o_borrow_out,
    output logic [DIGIT_W-1:0] o_dec_value
);

    logic w_is_zero;

    assign w_is_zero    = (i_value == '0);
    assign o_borrow_out = i_borrow_in & w_is_zero;

    always_comb begin
        o_dec_value = i_value;
        if (i_borrow_in) begin
            o_dec_value = w_is_zero ? 4'd9 : (i_value - 4'd1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_down_timer.sv
// ============================================================================
// Module : bcd_down_timer
// Brief  : NDIG-digit BCD down timer with IDLE/RUN/DONE FSM and auto-reload
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_timer
    import bcd_timer_pkg::*;
#(
    parameter int NDIG = 2
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    load,
    input  logic [DIGIT_W*NDIG-1:0] load_val,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    en,
    input  logic                    auto_reload,
    output logic [DIGIT_W*NDIG-1:0] Q,
    output logic [1:0]              state,
    output logic                    tc,
    output logic                    done
);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [DIGIT_W*NDIG-1:0] r_q;
    logic [DIGIT_W*NDIG-1:0] w_q_nxt;
    logic [DIGIT_W*NDIG-1:0] r_reload;
    logic [DIGIT_W*NDIG-1:0] w_reload_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic [DIGIT_W*NDIG-1:0] w_q_dec;
    logic [DIGIT_W*NDIG-1:0] w_load_clamped;
    logic [NDIG:0]           w_borrow;
    logic                    w_zero;

    // Decrement injects a borrow at digit 0; the borrow leaving the top digit
    // is therefore set exactly when every digit is zero.
    assign w_borrow[0] = 1'b1;
    assign w_zero      = w_borrow[NDIG];

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        bcd_down_digit u_digit (
            .i_value      (r_q[i*DIGIT_W +: DIGIT_W]),
            .i_borrow_in  (w_borrow[i]),
            .o_borrow_out (w_borrow[i+1]),
            .o_dec_value  (w_q_dec[i*DIGIT_W +: DIGIT_W])
        );
        assign w_load_clamped[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_val[i*DIGIT_W +: DIGIT_W]);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_q      <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_reload <= w_reload_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;
        if (load) begin
            w_q_nxt      = w_load_clamped;
            w_reload_nxt = w_load_clamped;
            if (r_state == ST_DONE) begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !w_zero) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (en) begin
                        if (w_zero) begin
                            w_done_nxt = 1'b1;
                            if (auto_reload) begin
                                w_q_nxt = r_reload;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
                            w_q_nxt = w_q_dec;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        w_q_nxt     = r_reload;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Q     = r_q;
        state = r_state;
        done  = r_done;
        tc    = w_zero;
    end

endmodule

`default_nettype wire
